// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: access sizes, FSM states,
// owner encoding and the registered request record.
package mem_arb_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Address is kept outside the record because its width is a top-level parameter.
    typedef struct packed {
        owner_t      owner;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: byte enables, store-data replication,
// load shift/extend and misalignment detection.
module lsu_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;
        unique case (size)
            SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = uns ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = uns ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
            end
            SIZE_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = shifted;
            end
            default: ;
        endcase
    end

    assign misalign = (size == SIZE_ILL)
                   || (size == SIZE_HALF && addr_lo[0])
                   || (size == SIZE_WORD && addr_lo != 2'b00);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin tie-breaking instead of fixed data priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t            state;
    req_t              rq;
    logic [ADDR_W-1:0] rq_addr;

    logic        idle, prio_d, sel_d, sel_if, rsp;
    logic [1:0]  al_addr, al_size;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;
    logic        al_misalign;

    assign idle = (state == IDLE);

`ifdef MEM_ARB_RR_EN
    owner_t last_own;
    assign prio_d = (last_own == OWN_IF);
`else
    assign prio_d = 1'b1;
`endif

    assign sel_d  = idle && d_req && (!if_req || prio_d);
    assign sel_if = idle && if_req && !sel_d;

    // In IDLE the aligner checks the incoming data request; afterwards it
    // works from the registered fields for enables and load extension.
    assign al_addr = idle ? d_addr[1:0] : rq_addr[1:0];
    assign al_size = idle ? d_size      : rq.size;

    lsu_align u_align (
        .addr_lo   (al_addr),
        .size      (al_size),
        .uns       (rq.uns),
        .wdata     (rq.wdata),
        .rdata     (mem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata),
        .misalign  (al_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rq      <= '0;
            rq_addr <= '0;
            mem_req <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_own <= OWN_IF;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_d) begin
                        rq.owner <= OWN_D;
                        rq.we    <= d_we;
                        rq.size  <= d_size;
                        rq.uns   <= d_unsigned;
                        rq.wdata <= d_wdata;
                        rq_addr  <= d_addr;
`ifdef MEM_ARB_RR_EN
                        last_own <= OWN_D;
`endif
                        if (al_misalign) begin
                            state <= ERR;
                        end else begin
                            state   <= ISSUE;
                            mem_req <= 1'b1;
                        end
                    end else if (sel_if) begin
                        rq.owner <= OWN_IF;
                        rq.we    <= 1'b0;
                        rq.size  <= SIZE_WORD;
                        rq.uns   <= 1'b0;
                        rq.wdata <= 32'h0;
                        rq_addr  <= if_addr & WORD_MASK;
`ifdef MEM_ARB_RR_EN
                        last_own <= OWN_IF;
`endif
                        state   <= ISSUE;
                        mem_req <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) state <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_ready = sel_if;
    assign d_ready  = sel_d;

    assign mem_we    = mem_req & rq.we;
    assign mem_addr  = mem_req ? (rq_addr & WORD_MASK) : '0;
    assign mem_be    = mem_req ? al_be : 4'b0000;
    assign mem_wdata = mem_req ? al_wdata : 32'h0;

    // Responses are same-cycle with the memory's rvalid.
    assign rsp       = (state == WAIT) && mem_rvalid;
    assign if_rvalid = rsp && (rq.owner == OWN_IF);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rvalid  = (rsp && (rq.owner == OWN_D)) || (state == ERR);
    assign d_rdata   = (rsp && (rq.owner == OWN_D) && !rq.we) ? al_rdata : 32'h0;
    assign d_err     = (state == ERR);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between instruction fetch and the load/store path of the RISC-V core. It accepts one request at a time from either requester and issues it on the memory port with byte enables and store-data replication. It returns load data aligned, sign- or zero-extended according to the size and unsigned controls from the decode controller, and flags misaligned accesses without touching memory.

## Interface
- ADDR_W, 32, byte address width (data path fixed at 32 bits)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  ADDR_W  fetch byte address (word-aligned by design, low 2 bits ignored)
- if_ready  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  instruction word
- d_req  in  1  data request; d_* fields held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data, LSB-justified
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_unsigned  in  1  zero-extend load result
- d_ready  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: data response (load data or store ack)
- d_rdata  out  32  extended load result; 0 for stores and errors
- d_err  out  1  valid with d_rvalid: misaligned or illegal size
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word address (bits [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  replicated store data
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory response (read data or write ack)
- mem_rdata  in  32  memory read word

## Operation
- FSM states IDLE, ISSUE, WAIT, ERR.
- IDLE: if any request, select owner, register address/size/unsigned/we/wdata, pulse the owner's *_ready; go ISSUE, or ERR if data request is misaligned (half with addr[0]=1, word with addr[1:0]!=0) or d_size=11.
- ISSUE: mem_req=1 from registered fields; on mem_gnt -> WAIT.
- WAIT: on mem_rvalid pulse owner's *_rvalid with data this cycle -> IDLE.
- ERR: d_rvalid=1, d_err=1, d_rdata=0 -> IDLE; no memory access.
- Arbitration with both requesting: data wins (older instruction).
- mem_be: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111; loads also drive these enables.
- mem_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load: shift mem_rdata right by 8*addr[1:0]; extend bit 7 (byte) or bit 15 (half) unless d_unsigned.
- mem_rvalid outside WAIT ignored; mem_gnt outside ISSUE ignored.

## Timing
- Reset: state IDLE; all outputs 0; registered fields 0.
- rst_n low mid-transaction: abort immediately, no response pulse; memory reset together.
- Minimum latency: request cycle 0 (ready), mem_req cycle 1, gnt cycle 1, rvalid cycle 2 (response same cycle), next accept cycle 3.
- mem_req stays high with stable fields through any number of gnt-low cycles.
- Responses are combinational from mem_rvalid/mem_rdata in WAIT; ready pulses only in IDLE.
- Error path: accept cycle 0, d_rvalid/d_err cycle 1.

## Configuration
- MEM_ARB_RR_EN defined: with both requesting, grant goes to the requester not served last (one-bit last-owner register, reset = fetch, so data wins first tie).
- Undefined: fixed data priority; last-owner register absent.

## Structure
- mem_arb_pkg: size constants SIZE_BYTE/HALF/WORD (00/01/10, matching decode encoding), state enum, owner enum (OWN_IF, OWN_D).
- Sub-module lsu_align: combinational be/wdata generation, load shift/extend, misalign detect.

## Test plan
- Fetch only, if_addr=0x100, mem_rdata=0x00500093 with gnt immediate, rvalid cycle 2 -> if_rvalid cycle 2, if_rdata=0x00500093, mem_addr=0x100, mem_be=1111.
- Load byte signed addr 0x203, mem_rdata=0x80FF0011 -> mem_be=1000, d_rdata=0xFFFFFF80; same with d_unsigned=1 -> 0x00000080.
- Store half addr 0x42, d_wdata=0x0000BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF, mem_addr=0x40; d_rvalid on write ack, d_rdata=0.
- Misaligned word load addr 0x205 -> d_ready cycle 0, d_rvalid+d_err cycle 1, mem_req never asserted.
- Both requesting repeatedly, mem_gnt held low 3 cycles -> mem_req/fields stable; data served first; with MEM_ARB_RR_EN owners alternate, without it fetch waits until d_req drops.
- rst_n low in WAIT -> all outputs 0 immediately; later mem_rvalid produces no response.
